// File: rtl/lane_permute_stage.sv
// Two-stage valid/ready pipeline that permutes byte lanes of a beat.
// S1 captures op/sel/data; the S1->S2 transfer applies the lane permutation.
module lane_permute_stage #(
    parameter int LANES  = 8,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [6:0]               in_op_i,
    input  logic [LANES*3-1:0]       in_sel_i,
    input  logic [LANES*LANE_W-1:0]  in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LANES*LANE_W-1:0]  out_data_o,
    output logic [6:0]               out_op_o,
    output logic                     illegal_o,
    output logic [CNT_W-1:0]         xfer_cnt_o,
    input  logic                     clr_i
);

    typedef enum logic [6:0] {
        ALU_N   = 7'd0,
        ALU_B   = 7'd1,
        ALU_H   = 7'd2,
        ALU_BFP = 7'd3
    } op_e;

    logic                    r_s1_valid;
    logic [6:0]              r_s1_op;
    logic [LANES*3-1:0]      r_s1_sel;
    logic [LANES*LANE_W-1:0] r_s1_data;

    logic                    r_s2_valid;
    logic [6:0]              r_s2_op;
    logic [LANES*LANE_W-1:0] r_s2_data;

    logic                    r_illegal;
    logic [CNT_W-1:0]        r_xfer_cnt;

    logic                    w_s1_advance;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [LANE_W-1:0]       w_lane [LANES];
    logic [LANES*LANE_W-1:0] w_perm;

    assign w_s1_advance = r_s1_valid && (!r_s2_valid || out_ready_i);
    assign in_ready_o   = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid_i && in_ready_o;
    assign w_out_fire   = r_s2_valid && out_ready_i;

    always_comb begin
        // NOTE: every output of a comb block gets a default first, so no path leaves it unassigned and infers a latch.
        w_perm = r_s1_data;
        for (int k = 0; k < LANES; k++) begin
            w_lane[k] = r_s1_data[LANE_W*k +: LANE_W];
        end
        if (r_s1_op <= ALU_H) begin
            for (int k = 0; k < LANES; k++) begin
                w_perm[LANE_W*k +: LANE_W] = w_lane[r_s1_sel[3*k +: 3]];
            end
        end
    end

    // NOTE: the data registers are reset too, because out_data_o/out_op_o must read 0 while rst_ni is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_sel   <= '0;
            r_s1_data  <= '0;
        end else if (w_in_fire) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_s1_valid <= 1'b1;
            r_s1_op    <= in_op_i;
            r_s1_sel   <= in_sel_i;
            r_s1_data  <= in_data_i;
        end else if (w_s1_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= '0;
            r_s2_data  <= '0;
        end else if (w_s1_advance) begin
            r_s2_valid <= 1'b1;
            r_s2_op    <= r_s1_op;
            r_s2_data  <= w_perm;
        end else if (w_out_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Clear has priority over a same-cycle set or increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_illegal  <= 1'b0;
            r_xfer_cnt <= '0;
        end else if (clr_i) begin
            r_illegal  <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_in_fire && (in_op_i > ALU_BFP)) begin
                r_illegal <= 1'b1;
            end
            if (w_out_fire) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign out_data_o  = r_s2_data;
    assign out_op_o    = r_s2_op;
    assign illegal_o   = r_illegal;
    assign xfer_cnt_o  = r_xfer_cnt;

endmodule

// File: tb/tb_lane_permute_stage.sv
// Directed bench for lane_permute_stage: permutes, latency, backpressure,
// sticky illegal flag, counter wrap/clear and mid-flight reset.
module tb_lane_permute_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [6:0]  in_op_i;
    logic [23:0] in_sel_i;
    logic [63:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_data_o;
    logic [6:0]  out_op_o;
    logic        illegal_o;
    logic [3:0]  xfer_cnt_o;
    logic        clr_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  exp_cnt  = '0;
    logic        exp_illegal = 1'b0;

    localparam logic [23:0] SEL_ID  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] SEL_REV = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [23:0] SEL_ROT = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

    lane_permute_stage #(.LANES(8), .LANE_W(8), .CNT_W(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_op_i     (in_op_i),
        .in_sel_i    (in_sel_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_op_o    (out_op_o),
        .illegal_o   (illegal_o),
        .xfer_cnt_o  (xfer_cnt_o),
        .clr_i       (clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [6:0] op, input logic [23:0] sel,
                                          input logic [63:0] d);
        logic [63:0] r;
        logic [2:0]  s;
        r = d;
        if (op <= 7'd2) begin
            for (int k = 0; k < 8; k++) begin
                s = sel[3*k +: 3];
                r[8*k +: 8] = d[8*s +: 8];
            end
        end
        return r;
    endfunction

    task automatic beat(input int i, output logic [6:0] op, output logic [23:0] sel,
                        output logic [63:0] d);
        op  = (i == 5) ? 7'd6 : 7'(i % 4);
        sel = (i % 2 == 0) ? SEL_REV : SEL_ROT;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(16 * i + k);
    endtask

    // Single beat through an empty pipeline with out_ready_i held high.
    task automatic send_one(input logic [6:0] op, input logic [23:0] sel,
                            input logic [63:0] d, input logic [63:0] exp);
        check("pre_illegal", illegal_o, exp_illegal);
        in_valid_i = 1'b1;
        in_op_i    = op;
        in_sel_i   = sel;
        in_data_i  = d;
        tick();
        in_valid_i  = 1'b0;
        exp_illegal = exp_illegal | (op > 7'd3);
        check("lat1_valid", out_valid_o, 1'b0);
        check("illegal", illegal_o, exp_illegal);
        tick();
        check("lat2_valid", out_valid_o, 1'b1);
        check("data", out_data_o, exp);
        check("op", out_op_o, op);
        tick();
        exp_cnt++;
        check("xfer_cnt", xfer_cnt_o, exp_cnt);
        check("drained", out_valid_o, 1'b0);
    endtask

    task automatic run_stream(input int n, input bit bp);
        logic [63:0] q[$];
        logic [6:0]  op;
        logic [23:0] sel;
        logic [63:0] d;
        logic [63:0] front;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        beat(0, op, sel, d);
        in_valid_i  = 1'b1;
        in_op_i     = op;
        in_sel_i    = sel;
        in_data_i   = d;
        out_ready_i = 1'b1;
        while (got < n && cyc < 300) begin
            @(negedge clk_i);
            check("in_ready", in_ready_o, !(q.size() == 2 && !out_ready_i));
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    check("spurious_beat", out_valid_o, 1'b0);
                end else begin
                    front = q.pop_front();
                    check("stream_data", out_data_o, front);
                    got++;
                    exp_cnt++;
                end
            end
            if (in_valid_i && in_ready_o) begin
                q.push_back(model(in_op_i, in_sel_i, in_data_i));
                exp_illegal = exp_illegal | (in_op_i > 7'd3);
                sent++;
            end
            tick();
            cyc++;
            check("stream_cnt", xfer_cnt_o, exp_cnt);
            if (sent < n) begin
                beat(sent, op, sel, d);
                in_op_i   = op;
                in_sel_i  = sel;
                in_data_i = d;
            end else begin
                in_valid_i = 1'b0;
            end
            out_ready_i = bp ? (cyc % 3 == 0) : 1'b1;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check("stream_count", got, n);
        if (!bp) check("stream_cycles", cyc, n + 2);
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        tick();
        clr_i       = 1'b0;
        exp_cnt     = '0;
        exp_illegal = 1'b0;
        check("clr_illegal", illegal_o, 1'b0);
        check("clr_cnt", xfer_cnt_o, 4'd0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_op_i     = '0;
        in_sel_i    = '0;
        in_data_i   = '0;
        out_ready_i = 1'b1;
        clr_i       = 1'b0;

        #12;
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_illegal", illegal_o, 1'b0);
        check("rst_cnt", xfer_cnt_o, 4'd0);
        check("rst_data", out_data_o, 64'd0);
        check("rst_op", out_op_o, 7'd0);
        check("rst_in_ready", in_ready_o, 1'b1);
        tick();
        rst_ni = 1'b1;

        // Handshake happens on the first edge after release.
        send_one(7'd0, SEL_REV, 64'h0706050403020100, 64'h0001020304050607);
        send_one(7'd1, {8{3'd3}}, 64'h8877665544332211, 64'h4444444444444444);
        send_one(7'd2, SEL_ROT, 64'h8877665544332211, 64'h1188776655443322);
        send_one(7'd3, SEL_REV, 64'h8877665544332211, 64'h8877665544332211);
        send_one(7'd5, 24'd0, 64'h1122334455667788, 64'h1122334455667788);
        check("illegal_sticky", illegal_o, 1'b1);
        pulse_clr();

        run_stream(8, 1'b1);
        check("stream_illegal", illegal_o, exp_illegal);
        pulse_clr();

        run_stream(17, 1'b0);

        // Clear with a beat held in S2, then clear colliding with a consume.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_op_i     = 7'd0;
        in_sel_i    = SEL_ID;
        in_data_i   = 64'hA1A2A3A4A5A6A7A8;
        tick();
        in_valid_i = 1'b0;
        tick();
        check("hold_valid", out_valid_o, 1'b1);
        pulse_clr();
        check("clr_keeps_valid", out_valid_o, 1'b1);
        check("clr_keeps_data", out_data_o, 64'hA1A2A3A4A5A6A7A8);
        out_ready_i = 1'b1;
        clr_i       = 1'b1;
        tick();
        clr_i = 1'b0;
        check("collision_cnt", xfer_cnt_o, 4'd0);
        check("collision_consumed", out_valid_o, 1'b0);

        // Fill both stages, then reset asynchronously mid-cycle.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 64'h1111111111111111;
        tick();
        in_data_i = 64'h2222222222222222;
        tick();
        check("full_in_ready", in_ready_o, 1'b0);
        check("full_out_valid", out_valid_o, 1'b1);
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_out_valid", out_valid_o, 1'b0);
        check("async_data", out_data_o, 64'd0);
        check("async_in_ready", in_ready_o, 1'b1);
        tick();
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        exp_cnt     = '0;
        exp_illegal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale_beat", out_valid_o, 1'b0);
        end
        check("post_rst_cnt", xfer_cnt_o, 4'd0);
        send_one(7'd2, SEL_ROT, 64'h0F0E0D0C0B0A0908, 64'h080F0E0D0C0B0A09);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
